fft_test: RTL and testbench
===========================

Name: fft_test

Overview:
- Self-contained 8-point radix-2 decimation-in-time FFT test engine.
- A rising edge on data_flag starts one run:
  - loads a built-in test pattern from a ROM into an internal complex buffer,
  - runs three butterfly stages in place,
  - streams the 8 complex bins out in natural order.
- Used as a top-level smoke test for the FFT datapath; all outputs are observation-only.

Parameters:
- DW, 16, width of signed test samples (real part; imaginary input is 0).
- OW, DW+3, width of signed internal and output words; no scaling, growth of log2(8) bits.
- AMP, 1000, signed amplitude of the test pattern (must fit DW).
- PATTERN, 0, test pattern select:
  - 0 = DC: every sample = AMP.
  - 1 = impulse: x[0] = AMP, others 0.
  - 2 = alternating: +AMP on even n, -AMP on odd n.
  - Any other value behaves as 0.

Ports:
- sys_clk, input, 1, single clock; all logic on its rising edge.
- sys_rst, input, 1, asynchronous active-low reset.
- data_flag, input, 1, start request; rising edge triggers one run.
- busy, output, 1, high from the cycle after the start is accepted until done.
- fft_valid, output, 1, high while fft_index/fft_re/fft_im carry a bin.
- fft_index, output, 3, bin number k (natural order 0..7).
- fft_re, output, OW, signed real part of X[k].
- fft_im, output, OW, signed imaginary part of X[k].
- done, output, 1, one-cycle pulse after the last bin.

Behaviour:
- Reset (sys_rst = 0, asynchronous):
  - state = IDLE; busy, fft_valid, done, fft_index, fft_re, fft_im all 0.
  - The data_flag edge-detect register is cleared to 0.
  - Buffer contents are don't-care.
- Start detect: data_flag is registered. Start = data_flag & ~data_flag_q, sampled only in IDLE.
  - Edges during a run are ignored.
  - A level held high triggers exactly once.
- States: IDLE -> LOAD -> BFLY -> OUT -> DONE -> IDLE. Cycle counts are relative to edge E0, which samples the start.
- LOAD, cycles 1..8:
  - Sample n (sign-extended to OW, imaginary 0) is written to buffer address bitrev3(n).
- BFLY, cycles 9..32:
  - 3 stages × 4 butterflies × 2 cycles.
  - Cycle A reads both operands into registers; cycle B computes and writes back.
  - Stage s (s = 0,1,2) has span h = 2^s.
  - Butterfly pairs are (i, i+h) for all i with bit s clear, in increasing i.
  - Twiddle W8^m, m = (i mod h)·(4/h).
  - Result: top = a + b·W, bottom = a − b·W.
- Twiddle ROM, Q1.14 signed 16-bit:
  - W0 = (16384, 0)
  - W1 = (11585, −11585)
  - W2 = (0, −16384)
  - W3 = (−11585, −11585)
- Complex multiply: each product is (p + 8192) >>> 14, arithmetic shift. Results are truncated to OW bits; OW is sized so the defined patterns never overflow.
- OUT, cycles 33..40:
  - fft_valid = 1, fft_index = k = 0..7, fft_re/fft_im = X[k] from buffer address k.
  - Outputs are registered.
- DONE, cycle 41:
  - done = 1 for one cycle; busy drops in the same cycle.
  - fft_valid = 0; data outputs return to 0.
  - Back in IDLE at cycle 42, where a new start may be accepted.
- Reset mid-run: immediate return to IDLE with all outputs 0; no done pulse. A later start performs a full fresh run.

Optional Feature:
- Macro: FFT_INV_EN.
- Defined:
  - Adds input port inverse (1 bit), sampled with the start.
  - inverse = 1 uses conjugated twiddles (imaginary sign flipped): W1 = (11585, 11585), W2 = (0, 16384), W3 = (−11585, 11585).
  - No 1/8 scaling.
  - inverse = 0 is identical to the build without the macro.
- Undefined: no inverse port; forward transform only.

Test Plan:
- Reset then idle, data_flag = 0 for 25 cycles -> busy = fft_valid = done = 0, fft_re = fft_im = 0.
- PATTERN = 0, AMP = 1000, one-cycle data_flag pulse -> fft_valid for 8 cycles starting 33 cycles after the sampling edge; X[0] = (8000, 0), X[1..7] = (0, 0); done pulses at cycle 41.
- PATTERN = 1, AMP = 1000 -> all 8 bins = (1000, 0); fft_index sequence 0..7.
- PATTERN = 2, AMP = 1000 -> X[4] = (8000, 0), all other bins (0, 0).
- data_flag held high 100 cycles, plus a second pulse at cycle 20 of the run -> exactly one run, one done pulse.
- sys_rst low at cycle 15 of a run, released, then a new pulse -> outputs 0 during reset, no done; the new run yields the correct full result.

Source files
------------

// File: rtl/fft_test.sv
// 8-point radix-2 DIT FFT smoke-test engine: ROM pattern -> in-place butterflies -> natural-order bins.
// Optional build macro FFT_INV_EN adds an 'inverse' input that selects conjugated twiddles.
module fft_test #(
    parameter int DW      = 16,
    parameter int OW      = DW + 3,
    parameter int AMP     = 1000,
    parameter int PATTERN = 0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 data_flag,
`ifdef FFT_INV_EN
    input  logic                 inverse,
`endif
    output logic                 busy,
    output logic                 fft_valid,
    output logic [2:0]           fft_index,
    output logic signed [OW-1:0] fft_re,
    output logic signed [OW-1:0] fft_im,
    output logic                 done
);

    localparam int PW = OW + 16;
    localparam logic signed [PW-1:0] RND   = PW'(8192);
    localparam logic signed [OW-1:0] AMP_P = OW'(AMP);
    localparam logic signed [OW-1:0] AMP_N = OW'(-AMP);

    typedef enum logic [2:0] {IDLE, LOAD, BFLY, OUT, DONE} state_t;

    // State and step counter live in one struct so checkers can bind to a single signal.
    typedef struct packed {
        state_t     state;
        logic [4:0] cnt;
    } fsm_t;

    fsm_t fsm_q, fsm_d;

    logic                 data_flag_q;
    logic                 start;
    logic                 inv_q;
    logic                 busy_d, valid_d, done_d;
    logic [2:0]           idx_d;
    logic signed [OW-1:0] re_d, im_d;

    logic signed [OW-1:0] mem_re [8];
    logic signed [OW-1:0] mem_im [8];
    logic signed [OW-1:0] a_re, a_im, b_re, b_im;

    logic [2:0]           bf_i, bf_p;
    logic [1:0]           tw_m;
    logic signed [15:0]   w_re, w_im;
    logic signed [OW-1:0] t_re, t_im;

    assign start = data_flag & ~data_flag_q;

    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

    function automatic logic signed [OW-1:0] sample(input logic [2:0] n);
        logic signed [OW-1:0] v;
        case (PATTERN)
            1:       v = (n == 3'd0) ? AMP_P : '0;
            2:       v = n[0] ? AMP_N : AMP_P;
            default: v = AMP_P;
        endcase
        return v;
    endfunction

    // Q1.14 product with round-half-up before the arithmetic shift.
    function automatic logic signed [OW-1:0] qmul(input logic signed [OW-1:0] x,
                                                   input logic signed [15:0]   w);
        logic signed [PW-1:0] p;
        p = PW'(x) * PW'(w) + RND;
        return OW'(p >>> 14);
    endfunction

    // cnt[4:3] = stage, cnt[2:1] = butterfly within stage, cnt[0] = read/write phase.
    always_comb begin
        bf_i = '0;
        bf_p = '0;
        tw_m = '0;
        case (fsm_q.cnt[4:3])
            2'd0: begin
                bf_i = {fsm_q.cnt[2:1], 1'b0};
                bf_p = bf_i | 3'd1;
                tw_m = 2'd0;
            end
            2'd1: begin
                bf_i = {fsm_q.cnt[2], 1'b0, fsm_q.cnt[1]};
                bf_p = bf_i | 3'd2;
                tw_m = {fsm_q.cnt[1], 1'b0};
            end
            default: begin
                bf_i = {1'b0, fsm_q.cnt[2:1]};
                bf_p = bf_i | 3'd4;
                tw_m = fsm_q.cnt[2:1];
            end
        endcase
    end

    always_comb begin
        w_re = 16'sd16384;
        w_im = 16'sd0;
        case (tw_m)
            2'd1:    begin w_re =  16'sd11585; w_im = -16'sd11585; end
            2'd2:    begin w_re =  16'sd0;     w_im = -16'sd16384; end
            2'd3:    begin w_re = -16'sd11585; w_im = -16'sd11585; end
            default: begin w_re =  16'sd16384; w_im =  16'sd0;     end
        endcase
        if (inv_q) w_im = -w_im;
    end

    assign t_re = qmul(b_re, w_re) - qmul(b_im, w_im);
    assign t_im = qmul(b_re, w_im) + qmul(b_im, w_re);

`ifdef FFT_INV_EN
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst)                               inv_q <= 1'b0;
        else if (fsm_q.state == IDLE && start)      inv_q <= inverse;
    end
`else
    assign inv_q = 1'b0;
`endif

    // Buffer and operand registers carry no reset: their contents are rewritten every run.
    always_ff @(posedge sys_clk) begin
        if (fsm_q.state == LOAD) begin
            mem_re[bitrev3(fsm_q.cnt[2:0])] <= sample(fsm_q.cnt[2:0]);
            mem_im[bitrev3(fsm_q.cnt[2:0])] <= '0;
        end else if (fsm_q.state == BFLY) begin
            if (!fsm_q.cnt[0]) begin
                a_re <= mem_re[bf_i];
                a_im <= mem_im[bf_i];
                b_re <= mem_re[bf_p];
                b_im <= mem_im[bf_p];
            end else begin
                mem_re[bf_i] <= a_re + t_re;
                mem_im[bf_i] <= a_im + t_im;
                mem_re[bf_p] <= a_re - t_re;
                mem_im[bf_p] <= a_im - t_im;
            end
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        busy_d  = busy;
        valid_d = 1'b0;
        idx_d   = '0;
        re_d    = '0;
        im_d    = '0;
        done_d  = 1'b0;
        case (fsm_q.state)
            IDLE: begin
                if (start) begin
                    fsm_d.state = LOAD;
                    fsm_d.cnt   = '0;
                    busy_d      = 1'b1;
                end
            end
            LOAD: begin
                if (fsm_q.cnt == 5'd7) begin
                    fsm_d.state = BFLY;
                    fsm_d.cnt   = '0;
                end else begin
                    fsm_d.cnt = fsm_q.cnt + 5'd1;
                end
            end
            BFLY: begin
                if (fsm_q.cnt == 5'd23) begin
                    // Bin 0 is preloaded so the first valid cycle lines up with entry into OUT.
                    fsm_d.state = OUT;
                    fsm_d.cnt   = '0;
                    valid_d     = 1'b1;
                    re_d        = mem_re[0];
                    im_d        = mem_im[0];
                end else begin
                    fsm_d.cnt = fsm_q.cnt + 5'd1;
                end
            end
            OUT: begin
                if (fsm_q.cnt == 5'd7) begin
                    fsm_d.state = DONE;
                    fsm_d.cnt   = '0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    fsm_d.cnt = fsm_q.cnt + 5'd1;
                    valid_d   = 1'b1;
                    idx_d     = fsm_q.cnt[2:0] + 3'd1;
                    re_d      = mem_re[idx_d];
                    im_d      = mem_im[idx_d];
                end
            end
            DONE: begin
                fsm_d.state = IDLE;
                busy_d      = 1'b0;
            end
            default: begin
                fsm_d.state = IDLE;
                fsm_d.cnt   = '0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            fsm_q.state <= IDLE;
            fsm_q.cnt   <= '0;
            data_flag_q <= 1'b0;
            busy        <= 1'b0;
            fft_valid   <= 1'b0;
            fft_index   <= '0;
            fft_re      <= '0;
            fft_im      <= '0;
            done        <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            data_flag_q <= data_flag;
            busy        <= busy_d;
            fft_valid   <= valid_d;
            fft_index   <= idx_d;
            fft_re      <= re_d;
            fft_im      <= im_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_fft_test.sv
// Directed bench for fft_test: one instance per pattern (DC, impulse, alternating) sharing clock/reset/start.
module tb_fft_test;

    localparam int OW = 19;

    logic sys_clk;
    logic sys_rst;
    logic data_flag;

    logic                 busy_w      [3];
    logic                 fft_valid_w [3];
    logic [2:0]           fft_index_w [3];
    logic signed [OW-1:0] fft_re_w    [3];
    logic signed [OW-1:0] fft_im_w    [3];
    logic                 done_w      [3];

    int n_cmp = 0;
    int n_err = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fft_test #(.DW(16), .OW(OW), .AMP(1000), .PATTERN(g)) u_dut (
            .sys_clk   (sys_clk),
            .sys_rst   (sys_rst),
            .data_flag (data_flag),
`ifdef FFT_INV_EN
            .inverse   (1'b0),
`endif
            .busy      (busy_w[g]),
            .fft_valid (fft_valid_w[g]),
            .fft_index (fft_index_w[g]),
            .fft_re    (fft_re_w[g]),
            .fft_im    (fft_im_w[g]),
            .done      (done_w[g])
        );
    end

    // Clock / reset
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected summary before 2 ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hand-derived spectra: DC -> 8000 in bin 0, impulse -> flat 1000, alternating -> 8000 in bin 4.
    function automatic int exp_re(input int p, input int k);
        case (p)
            1:       return 1000;
            2:       return (k == 4) ? 8000 : 0;
            default: return (k == 0) ? 8000 : 0;
        endcase
    endfunction

    task automatic check_quiet(input string tag);
        for (int p = 0; p < 3; p++) begin
            check({tag, "_busy"},  busy_w[p],      0);
            check({tag, "_valid"}, fft_valid_w[p], 0);
            check({tag, "_done"},  done_w[p],      0);
            check({tag, "_re"},    fft_re_w[p],    0);
            check({tag, "_im"},    fft_im_w[p],    0);
        end
    endtask

    // Pulse data_flag for one cycle and check every cycle 1..42 of the run; returns in cycle 42.
    task automatic run_full(input string tag);
        data_flag = 1'b1;
        @(negedge sys_clk);
        data_flag = 1'b0;
        for (int c = 1; c <= 42; c++) begin
            bit in_out;
            if (c > 1) @(negedge sys_clk);
            in_out = (c >= 33 && c <= 40);
            check($sformatf("%s_busy_c%0d", tag, c),  busy_w[0],      (c <= 40) ? 1 : 0);
            check($sformatf("%s_done_c%0d", tag, c),  done_w[0],      (c == 41) ? 1 : 0);
            for (int p = 0; p < 3; p++) begin
                check($sformatf("%s_p%0d_valid_c%0d", tag, p, c), fft_valid_w[p], in_out ? 1 : 0);
                check($sformatf("%s_p%0d_index_c%0d", tag, p, c), fft_index_w[p], in_out ? c - 33 : 0);
                check($sformatf("%s_p%0d_re_c%0d", tag, p, c), fft_re_w[p],
                      in_out ? exp_re(p, c - 33) : 0);
                check($sformatf("%s_p%0d_im_c%0d", tag, p, c), fft_im_w[p], 0);
            end
        end
    endtask

    initial begin
        int dones;
        int valids;

        sys_rst   = 1'b0;
        data_flag = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_quiet("in_reset");
        sys_rst = 1'b1;

        // Idle with no start request
        for (int c = 0; c < 25; c++) begin
            @(negedge sys_clk);
            check($sformatf("idle_busy_c%0d", c),  busy_w[0],      0);
            check($sformatf("idle_valid_c%0d", c), fft_valid_w[0], 0);
            check($sformatf("idle_done_c%0d", c),  done_w[0],      0);
        end
        check_quiet("idle");

        // Full run, then an immediate second start accepted at cycle 42
        run_full("run1");
        run_full("run2");
        repeat (3) @(negedge sys_clk);
        check_quiet("after_run2");

        // Level held high for 100 cycles with an extra rising edge at cycle 20
        dones  = 0;
        valids = 0;
        data_flag = 1'b1;
        @(negedge sys_clk);
        for (int c = 1; c <= 150; c++) begin
            if (c > 1) @(negedge sys_clk);
            if (c == 19)  data_flag = 1'b0;
            if (c == 20)  data_flag = 1'b1;
            if (c == 100) data_flag = 1'b0;
            if (done_w[0])      dones++;
            if (fft_valid_w[0]) valids++;
            if (c == 41) check("held_done_at_41", done_w[0], 1);
            if (c == 60) check("held_busy_at_60", busy_w[0], 0);
        end
        check("held_done_count",  dones,  1);
        check("held_valid_count", valids, 8);

        // Reset asserted mid-run at cycle 15
        data_flag = 1'b1;
        @(negedge sys_clk);
        data_flag = 1'b0;
        repeat (14) @(negedge sys_clk);
        check("midrun_busy_before_rst", busy_w[0], 1);
        sys_rst = 1'b0;
        #1;
        check_quiet("midrun_rst");
        dones = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge sys_clk);
            if (done_w[0]) dones++;
            check($sformatf("midrun_rst_busy_c%0d", c), busy_w[0], 0);
        end
        sys_rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge sys_clk);
            if (done_w[0] || busy_w[0]) dones++;
        end
        check("midrun_no_activity", dones, 0);
        run_full("run_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
